// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode encodings and fetch FSM states for the 16-bit CPU.
package cpu_pkg;
   localparam int CPU_ADDR_W = 8;
   localparam int CPU_DATA_W = 16;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_NOT = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [15:0] NOP   = 16'h0000;
   typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {instruction, pc} entries with flush and occupancy count.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int W     = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [W-1:0]             i_data,
   output logic [W-1:0]             o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [PW:0]   r_count;
   logic          w_do_pop;
   logic          w_do_push;
   assign o_count   = r_count;
   assign o_full    = r_count == (PW+1)'(DEPTH);
   assign o_empty   = r_count == '0;
   assign o_data    = r_mem[r_rd];
   assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
   // a full queue still accepts a push when the head leaves in the same cycle
   assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + PW'(1);
         end
         if (w_do_pop) r_rd <= r_rd + PW'(1);
         r_count <= r_count + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_do_pop};
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, the RUN/HALTED FSM and redirect priority; feeds decode through fetch_queue.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = CPU_ADDR_W,
   parameter int                DATA_W   = CPU_DATA_W,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [ADDR_W-1:0]      rom_addr,
   input  logic [DATA_W-1:0]      rom_data,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   input  logic                   halt_req,
   input  logic                   resume,
   output logic [DATA_W-1:0]      instr_out,
   output logic [ADDR_W-1:0]      instr_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic                   halted,
   output logic [$clog2(DEPTH):0] q_count
);
   fetch_state_t             r_state;
   logic [ADDR_W-1:0]        r_pc;
   logic                     r_halted;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_full;
   logic                     w_empty;
   logic [DATA_W+ADDR_W-1:0] w_head;
   assign rom_addr    = r_pc;
   assign halted      = r_halted;
   assign instr_valid = ~w_empty;
   assign w_pop       = instr_valid & instr_ready;
   // redirect cycles never fetch: the old pc's word belongs to the discarded path
   assign w_push      = (r_state == ST_RUN) & ~redirect_valid & (~w_full | w_pop);
   assign {instr_out, instr_pc} = w_head;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_state  <= ST_RUN;
         r_halted <= 1'b0;
      end else begin
         r_pc     <= redirect_valid ? redirect_pc : (w_push ? r_pc + ADDR_W'(1) : r_pc);
         r_state  <= halt_req ? ST_HALTED : (resume ? ST_RUN : r_state);
         r_halted <= halt_req ? 1'b1 : (resume ? 1'b0 : r_halted);
      end
   end
   fetch_queue #(.DEPTH(DEPTH), .W(DATA_W + ADDR_W)) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  ({rom_data, r_pc}),
      .o_data  (w_head),
      .o_count (q_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table plus randomized run against a queue-based reference model.
module tb_fetch_sequencer;
   localparam int DEPTH = 2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = '0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic [15:0] instr_out;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        halted;
   logic [1:0]  q_count;
   logic [15:0] rom [256];
   int          checks = 0;
   int          errors = 0;
   typedef struct {
      bit rst; bit rdy; bit rv; logic [7:0] rpc; bit hlt; bit res;
      bit ev; logic [15:0] eout; logic [7:0] epc; logic [1:0] ecnt; logic [7:0] eaddr; bit eh;
   } vec_t;
   vec_t        vecs[$];
   logic [23:0] mq[$];
   logic [7:0]  m_pc;
   bit          m_halt;

   always #5 clk = ~clk;
   assign rom_data = rom[rom_addr];

   fetch_sequencer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .resume(resume), .instr_out(instr_out),
      .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .halted(halted), .q_count(q_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rst, bit rdy, bit rv, logic [7:0] rpc, bit hlt, bit res,
                               bit ev, logic [15:0] eout, logic [7:0] epc, logic [1:0] ecnt,
                               logic [7:0] eaddr, bit eh);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt; v.res = res;
      v.ev = ev; v.eout = eout; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr; v.eh = eh;
      return v;
   endfunction

   task automatic model_step();
      bit pop;
      if (!rst_n) begin
         mq.delete();
         m_pc   = 8'd0;
         m_halt = 1'b0;
         return;
      end
      pop = mq.size() > 0 && instr_ready;
      if (redirect_valid) begin
         mq.delete();
         m_pc = redirect_pc;
      end else begin
         if (pop) void'(mq.pop_front());
         if (!m_halt && mq.size() < DEPTH) begin
            mq.push_back({rom[m_pc], m_pc});
            m_pc = m_pc + 8'd1;
         end
      end
      if (halt_req) m_halt = 1'b1;
      else if (resume) m_halt = 1'b0;
   endtask

   initial begin
      rom[0] = 16'h0600; rom[1] = 16'h1600; rom[2] = 16'h2400;
      rom[3] = 16'h3600; rom[4] = 16'h4600; rom[5] = 16'h5600;
      rom[6] = 16'h0000;
      for (int i = 7; i < 256; i++) rom[i] = 16'(i * 37) ^ 16'hA5C3;
      // reset, then streaming at full rate
      vecs.push_back(mk(0,1,0,0,0,0, 0,16'h0000,8'd0,2'd0,8'd0,0));
      for (int k = 1; k <= 7; k++)
         vecs.push_back(mk(1,1,0,0,0,0, 1,rom[k-1],8'(k-1),2'd1,8'(k),0));
      // decode stalled: queue fills to DEPTH, then drains without gap
      vecs.push_back(mk(0,0,0,0,0,0, 0,16'h0000,8'd0,2'd0,8'd0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 1,16'h0600,8'd0,2'd1,8'd1,0));
      vecs.push_back(mk(1,0,0,0,0,0, 1,16'h0600,8'd0,2'd2,8'd2,0));
      vecs.push_back(mk(1,0,0,0,0,0, 1,16'h0600,8'd0,2'd2,8'd2,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h1600,8'd1,2'd2,8'd3,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h2400,8'd2,2'd2,8'd4,0));
      // redirect to 4 while pc=2
      vecs.push_back(mk(0,1,0,0,0,0, 0,16'h0000,8'd0,2'd0,8'd0,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h0600,8'd0,2'd1,8'd1,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h1600,8'd1,2'd1,8'd2,0));
      vecs.push_back(mk(1,1,1,8'd4,0,0, 0,16'h0000,8'd0,2'd0,8'd4,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h4600,8'd4,2'd1,8'd5,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h5600,8'd5,2'd1,8'd6,0));
      // redirect to 255 and wrap
      vecs.push_back(mk(1,1,1,8'd255,0,0, 0,16'h0000,8'd0,2'd0,8'd255,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,rom[255],8'd255,2'd1,8'd0,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h0600,8'd0,2'd1,8'd1,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h1600,8'd1,2'd1,8'd2,0));
      // halt: the halt cycle still fetches pc 2, then pc holds at 3
      vecs.push_back(mk(1,1,0,0,1,0, 1,16'h2400,8'd2,2'd1,8'd3,1));
      vecs.push_back(mk(1,1,0,0,0,0, 0,16'h0000,8'd0,2'd0,8'd3,1));
      vecs.push_back(mk(1,1,0,0,0,0, 0,16'h0000,8'd0,2'd0,8'd3,1));
      vecs.push_back(mk(1,1,0,0,0,1, 0,16'h0000,8'd0,2'd0,8'd3,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h3600,8'd3,2'd1,8'd4,0));
      // halt and resume together: halt wins
      vecs.push_back(mk(1,1,0,0,1,1, 1,16'h4600,8'd4,2'd1,8'd5,1));
      vecs.push_back(mk(1,1,0,0,0,0, 0,16'h0000,8'd0,2'd0,8'd5,1));
      vecs.push_back(mk(1,1,0,0,0,1, 0,16'h0000,8'd0,2'd0,8'd5,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,16'h5600,8'd5,2'd1,8'd6,0));
      // redirect and halt together
      vecs.push_back(mk(1,1,1,8'h80,1,0, 0,16'h0000,8'd0,2'd0,8'h80,1));
      vecs.push_back(mk(1,1,0,0,0,0, 0,16'h0000,8'd0,2'd0,8'h80,1));
      vecs.push_back(mk(1,1,0,0,0,1, 0,16'h0000,8'd0,2'd0,8'h80,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,rom[8'h80],8'h80,2'd1,8'h81,0));

      @(negedge clk);
      foreach (vecs[n]) begin
         rst_n = vecs[n].rst; instr_ready = vecs[n].rdy; redirect_valid = vecs[n].rv;
         redirect_pc = vecs[n].rpc; halt_req = vecs[n].hlt; resume = vecs[n].res;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d valid", n), 32'(instr_valid), 32'(vecs[n].ev));
         chk($sformatf("vec%0d count", n), 32'(q_count), 32'(vecs[n].ecnt));
         chk($sformatf("vec%0d rom_addr", n), 32'(rom_addr), 32'(vecs[n].eaddr));
         chk($sformatf("vec%0d halted", n), 32'(halted), 32'(vecs[n].eh));
         if (vecs[n].ev || !vecs[n].rst) begin
            chk($sformatf("vec%0d instr_out", n), 32'(instr_out), 32'(vecs[n].eout));
            chk($sformatf("vec%0d instr_pc", n), 32'(instr_pc), 32'(vecs[n].epc));
         end
      end
      redirect_valid = 0; halt_req = 0; resume = 0; instr_ready = 1;

      // asynchronous reset in the middle of a cycle
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst valid", 32'(instr_valid), 32'd0);
      chk("async_rst count", 32'(q_count), 32'd0);
      chk("async_rst rom_addr", 32'(rom_addr), 32'd0);
      chk("async_rst instr_out", 32'(instr_out), 32'd0);
      chk("async_rst instr_pc", 32'(instr_pc), 32'd0);
      chk("async_rst halted", 32'(halted), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("restart valid", 32'(instr_valid), 32'd1);
      chk("restart instr_out", 32'(instr_out), 32'h0600);
      chk("restart instr_pc", 32'(instr_pc), 32'd0);

      // randomized run against the reference model
      rst_n = 1'b0;
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
         rst_n          = ($urandom_range(0, 299) != 0);
         instr_ready    = ($urandom_range(0, 9) < 6);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = 8'($urandom);
         halt_req       = ($urandom_range(0, 24) == 0);
         resume         = ($urandom_range(0, 5) == 0);
         @(posedge clk);
         model_step();
         @(negedge clk);
         chk($sformatf("rnd%0d valid", c), 32'(instr_valid), 32'(mq.size() > 0));
         chk($sformatf("rnd%0d count", c), 32'(q_count), 32'(mq.size()));
         chk($sformatf("rnd%0d rom_addr", c), 32'(rom_addr), 32'(m_pc));
         chk($sformatf("rnd%0d halted", c), 32'(halted), 32'(m_halt));
         if (mq.size() > 0) begin
            chk($sformatf("rnd%0d instr_out", c), 32'(instr_out), 32'(mq[0][23:8]));
            chk($sformatf("rnd%0d instr_pc", c), 32'(instr_pc), 32'(mq[0][7:0]));
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
